// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - state encoding and burst arithmetic shared by the scheduler
package mem_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_t;

  localparam int LINE_BYTES = 32;
  localparam int LINE_SHIFT = 5;

  function automatic logic [31:0] num_lines(input logic [31:0] size);
    return (size + 32'(LINE_BYTES - 1)) >> LINE_SHIFT;
  endfunction

  function automatic logic [5:0] tail_bytes(input logic [LINE_SHIFT-1:0] size_lo);
    return (size_lo == '0) ? 6'(LINE_BYTES) : {1'b0, size_lo};
  endfunction

endpackage

// File: rtl/mem_bank_scheduler_if.sv
// rtl/mem_bank_scheduler_if.sv - client burst bus and SRAM farm strobes of the scheduler
interface mem_bank_scheduler_if #(
  parameter int NUM_CLIENTS = 8,
  parameter int ADDR_WIDTH  = 19,
  parameter int SIZE_WIDTH  = 16,
  parameter int NUM_BANKS   = 16
);
  localparam int CW = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0]                 cl_req;
  logic [NUM_CLIENTS-1:0]                 cl_write;
  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] cl_addr;
  logic [NUM_CLIENTS-1:0][SIZE_WIDTH-1:0] cl_size;
  logic                                   prio_en;
  logic [CW-1:0]                          prio_client;
  logic                                   sram_stall;
  logic [NUM_CLIENTS-1:0]                 cl_gnt;
  logic [NUM_CLIENTS-1:0]                 cl_ack;
  logic [NUM_CLIENTS-1:0]                 cl_rvalid;
  logic                                   cl_last;
  logic [5:0]                             cl_nbytes;
  logic [NUM_CLIENTS-1:0]                 cl_done;
  logic [NUM_BANKS-1:0]                   sram_cs;
  logic                                   sram_we;
  logic [ADDR_WIDTH-10:0]                 sram_addr;
  logic                                   busy;

  modport slave (
    input  cl_req, cl_write, cl_addr, cl_size, prio_en, prio_client, sram_stall,
    output cl_gnt, cl_ack, cl_rvalid, cl_last, cl_nbytes, cl_done,
           sram_cs, sram_we, sram_addr, busy
  );

  modport master (
    output cl_req, cl_write, cl_addr, cl_size, prio_en, prio_client, sram_stall,
    input  cl_gnt, cl_ack, cl_rvalid, cl_last, cl_nbytes, cl_done,
           sram_cs, sram_we, sram_addr, busy
  );
endinterface

// File: rtl/mem_sched_rr_pick.sv
// rtl/mem_sched_rr_pick.sv - first set request at or after i_ptr, wrapping; one-hot and index out
module mem_sched_rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_found
);
  int w_c;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_c     = 0;
    for (int k = 0; k < N; k++) begin
      w_c = int'(i_ptr) + k;
      if (w_c >= N) w_c = w_c - N;
      if (!o_found && i_req[w_c]) begin
        o_found    = 1'b1;
        o_idx      = $clog2(N)'(w_c);
        o_gnt[w_c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_bank_scheduler.sv
// rtl/mem_bank_scheduler.sv - burst arbiter and per-line bank sequencer for the SRAM farm
// Optional wait-age override compiled in with MEM_SCHED_AGING_EN.
module mem_bank_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NUM_CLIENTS = 8,
  parameter int ADDR_WIDTH  = 19,
  parameter int SIZE_WIDTH  = 16,
  parameter int NUM_BANKS   = 16,
  parameter int AGE_LIMIT   = 64
) (
  input logic                 clk,
  input logic                 rst,
  mem_bank_scheduler_if.slave bus
);
  localparam int CW     = $clog2(NUM_CLIENTS);
  localparam int LINE_W = ADDR_WIDTH - LINE_SHIFT;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int REM_W  = SIZE_WIDTH - LINE_SHIFT + 1;

  sched_state_t           r_state, w_next_state;
  logic [NUM_CLIENTS-1:0] r_gnt;
  logic                   r_write;
  logic [LINE_W-1:0]      r_line;
  logic [REM_W-1:0]       r_remaining;
  logic [5:0]             r_tail;
  logic [CW-1:0]          r_rr_ptr;
  logic                   r_rd_valid, r_rd_last;
  logic [5:0]             r_rd_nbytes;

  logic [NUM_CLIENTS-1:0] w_rr_gnt, w_win_gnt;
  logic [CW-1:0]          w_rr_idx, w_win_idx;
  logic                   w_rr_found, w_prio_hit, w_issue, w_last_line;
  logic [5:0]             w_line_nbytes;
  logic [SIZE_WIDTH-1:0]  w_win_size;
  logic [31:0]            w_win_lines;

  mem_sched_rr_pick #(.N(NUM_CLIENTS)) u_rr_pick (
    .i_req(bus.cl_req), .i_ptr(r_rr_ptr),
    .o_gnt(w_rr_gnt), .o_idx(w_rr_idx), .o_found(w_rr_found)
  );

  assign w_prio_hit = bus.prio_en & bus.cl_req[bus.prio_client];

`ifdef MEM_SCHED_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0]       r_age [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] w_aged, w_age_gnt;
  logic [CW-1:0]          w_age_idx;
  logic                   w_age_found;

  always_comb begin
    w_aged = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      w_aged[i] = bus.cl_req[i] && (r_age[i] == AGE_W'(AGE_LIMIT));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (rst || r_gnt[i]) r_age[i] <= '0;
      else if (bus.cl_req[i] && r_age[i] != AGE_W'(AGE_LIMIT)) r_age[i] <= r_age[i] + AGE_W'(1);
    end
  end

  // Pointer fixed at 0 so the lowest aged index wins.
  mem_sched_rr_pick #(.N(NUM_CLIENTS)) u_age_pick (
    .i_req(w_aged), .i_ptr('0),
    .o_gnt(w_age_gnt), .o_idx(w_age_idx), .o_found(w_age_found)
  );

  always_comb begin
    w_win_gnt = w_rr_gnt;
    w_win_idx = w_rr_idx;
    if (w_age_found) begin
      w_win_gnt = w_age_gnt;
      w_win_idx = w_age_idx;
    end else if (w_prio_hit) begin
      w_win_gnt = NUM_CLIENTS'(1) << bus.prio_client;
      w_win_idx = bus.prio_client;
    end
  end
`else
  always_comb begin
    w_win_gnt = w_rr_gnt;
    w_win_idx = w_rr_idx;
    if (w_prio_hit) begin
      w_win_gnt = NUM_CLIENTS'(1) << bus.prio_client;
      w_win_idx = bus.prio_client;
    end
  end
`endif

  assign w_win_size    = bus.cl_size[w_win_idx];
  assign w_win_lines   = num_lines(32'(w_win_size));
  assign w_issue       = (r_state == ST_ISSUE) && !bus.sram_stall;
  assign w_last_line   = (r_remaining == REM_W'(1));
  assign w_line_nbytes = w_last_line ? r_tail : 6'(LINE_BYTES);

  logic [NUM_CLIENTS*LINE_SHIFT-1:0] w_unused_addr_lo;
  logic                              w_unused;
  always_comb begin
    w_unused_addr_lo = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      w_unused_addr_lo[i*LINE_SHIFT +: LINE_SHIFT] = bus.cl_addr[i][LINE_SHIFT-1:0];
  end
  assign w_unused = ^{w_unused_addr_lo, w_win_lines[31:REM_W], AGE_LIMIT};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_rr_found) w_next_state = (w_win_size == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (w_issue && w_last_line) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_write     <= 1'b0;
      r_line      <= '0;
      r_remaining <= '0;
      r_tail      <= '0;
      r_rr_ptr    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_nbytes <= '0;
    end else begin
      // Read data leaves the farm one cycle after its bank select.
      r_rd_valid  <= w_issue && !r_write;
      r_rd_last   <= w_issue && !r_write && w_last_line;
      r_rd_nbytes <= (w_issue && !r_write) ? w_line_nbytes : 6'd0;
      case (r_state)
        ST_IDLE: if (w_rr_found) begin
          r_gnt       <= w_win_gnt;
          r_write     <= bus.cl_write[w_win_idx];
          r_line      <= bus.cl_addr[w_win_idx][ADDR_WIDTH-1:LINE_SHIFT];
          r_remaining <= w_win_lines[REM_W-1:0];
          r_tail      <= tail_bytes(w_win_size[LINE_SHIFT-1:0]);
          r_rr_ptr    <= (w_win_idx == CW'(NUM_CLIENTS - 1)) ? '0 : w_win_idx + CW'(1);
        end
        ST_ISSUE: if (w_issue) begin
          r_line      <= r_line + LINE_W'(1);
          r_remaining <= r_remaining - REM_W'(1);
        end
        ST_DONE: r_gnt <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cl_gnt    = r_gnt;
    bus.cl_ack    = (w_issue && r_write) ? r_gnt : '0;
    bus.cl_rvalid = r_rd_valid ? r_gnt : '0;
    bus.cl_last   = (w_issue && r_write && w_last_line) || r_rd_last;
    bus.cl_nbytes = (w_issue && r_write) ? w_line_nbytes : r_rd_nbytes;
    bus.cl_done   = (r_state == ST_DONE) ? r_gnt : '0;
    bus.sram_cs   = w_issue ? (NUM_BANKS'(1) << r_line[BANK_W-1:0]) : '0;
    bus.sram_we   = w_issue && r_write;
    bus.sram_addr = w_issue ? r_line[LINE_W-1:BANK_W] : '0;
    bus.busy      = (r_state != ST_IDLE);
  end
endmodule

// File: tb/tb_mem_bank_scheduler.sv
// tb/tb_mem_bank_scheduler.sv - scoreboard bench: ordered grant/line/return/done model vs DUT
module tb_mem_bank_scheduler;
  localparam int N  = 8;
  localparam int AW = 19;
  localparam int SW = 16;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_bank_scheduler_if #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .NUM_BANKS(NB)) bus ();
  mem_bank_scheduler #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { logic we; logic [AW-1:0] addr; logic [SW-1:0] size; } burst_t;
  typedef struct { int owner; logic [NB-1:0] cs; logic [AW-10:0] row; logic we; logic [5:0] nb; logic last; } acc_t;
  typedef struct { int owner; logic last; logic [5:0] nb; } ret_t;

  burst_t drv_q [N][$];
  burst_t mdl_q [N][$];
  acc_t   acc_q [$];
  ret_t   ret_q [$];
  int     gnt_q [$];
  int     done_q[$];
  int     model_ptr = 0;
  int     last_done_cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_burst(input int c, input logic we, input logic [AW-1:0] addr, input int size);
    burst_t b;
    b.we = we; b.addr = addr; b.size = SW'(size);
    drv_q[c].push_back(b);
    mdl_q[c].push_back(b);
  endtask

  // Expected events of one burst; max_lines/full trim the stream for a burst cut short by reset.
  task automatic push_events(input int c, input burst_t b, input int max_lines, input bit full);
    int lines, tail, line, l;
    acc_t a;
    ret_t r;
    gnt_q.push_back(c);
    lines = (int'(b.size) + 31) / 32;
    tail  = (int'(b.size) % 32 == 0) ? 32 : int'(b.size) % 32;
    line  = int'(b.addr) / 32;
    for (int k = 0; k < lines && k < max_lines; k++) begin
      l       = (line + k) % (1 << (AW - 5));
      a.owner = c;
      a.cs    = NB'(1) << (l % NB);
      a.row   = (AW-9)'(l / NB);
      a.we    = b.we;
      a.last  = (k == lines - 1);
      a.nb    = a.last ? 6'(tail) : 6'd32;
      acc_q.push_back(a);
      if (!b.we && (full || k < max_lines - 1)) begin
        r.owner = c; r.last = a.last; r.nb = a.nb;
        ret_q.push_back(r);
      end
    end
    if (full) done_q.push_back(c);
  endtask

  function automatic bit mdl_pending();
    for (int c = 0; c < N; c++) if (mdl_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit drv_pending();
    for (int c = 0; c < N; c++) if (drv_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Every client with bursts left is requesting at each decision: priority, else round robin.
  task automatic schedule(input bit pen, input int pcl);
    int win, c;
    while (mdl_pending()) begin
      win = -1;
      if (pen && mdl_q[pcl].size() > 0) win = pcl;
      else begin
        for (int k = 0; k < N; k++) begin
          c = (model_ptr + k) % N;
          if (win < 0 && mdl_q[c].size() > 0) win = c;
        end
      end
      model_ptr = (win + 1) % N;
      push_events(win, mdl_q[win].pop_front(), 1 << 30, 1'b1);
    end
  endtask

  task automatic load(input int c);
    bus.cl_write[c] = drv_q[c][0].we;
    bus.cl_addr[c]  = drv_q[c][0].addr;
    bus.cl_size[c]  = drv_q[c][0].size;
    bus.cl_req[c]   = 1'b1;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_acc_left"}, 64'(acc_q.size()), 0);
    check({tag, "_ret_left"}, 64'(ret_q.size()), 0);
    check({tag, "_gnt_left"}, 64'(gnt_q.size()), 0);
    check({tag, "_done_left"}, 64'(done_q.size()), 0);
    acc_q.delete(); ret_q.delete(); gnt_q.delete(); done_q.delete();
  endtask

  // smode: 0 no stall, 1 random stall, 2 stall for relative cycles [s0, s1).
  task automatic run_scn(input string tag, input bit pen, input int pcl, input int smode,
                         input int s0, input int s1, output int dur);
    int start, guard, rel;
    logic [N-1:0] d;
    schedule(pen, pcl);
    bus.prio_en     = pen;
    bus.prio_client = 3'(pcl);
    @(posedge clk); #1;
    start = cyc;
    for (int c = 0; c < N; c++) if (drv_q[c].size() > 0) load(c); else bus.cl_req[c] = 1'b0;
    guard = 0;
    while (drv_pending() && guard < 5000) begin
      @(negedge clk);
      d = bus.cl_done;
      @(posedge clk); #1;
      guard++;
      for (int c = 0; c < N; c++) begin
        if (d[c] && drv_q[c].size() > 0) begin
          void'(drv_q[c].pop_front());
          if (drv_q[c].size() > 0) load(c); else bus.cl_req[c] = 1'b0;
        end
      end
      rel = cyc - start;
      case (smode)
        1:       bus.sram_stall = ($urandom % 5 == 0);
        2:       bus.sram_stall = (rel >= s0 && rel < s1);
        default: bus.sram_stall = 1'b0;
      endcase
    end
    if (guard >= 5000) begin
      check({tag, "_timeout"}, 1, 0);
      for (int c = 0; c < N; c++) drv_q[c].delete();
    end
    bus.sram_stall = 1'b0;
    bus.cl_req     = '0;
    dur = last_done_cyc - start;
    repeat (3) @(posedge clk);
    #1;
    check_drained(tag);
  endtask

  initial begin : monitor
    acc_t a;
    ret_t r;
    int   e;
    logic [N-1:0] pg;
    pg = '0;
    forever begin
      @(negedge clk);
      if (bus.cl_gnt != '0 && pg == '0) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", 64'(bus.cl_gnt), 0);
        else begin
          e = gnt_q.pop_front();
          check("gnt_owner", 64'(bus.cl_gnt), 64'(N'(1) << e));
        end
      end
      pg = bus.cl_gnt;
      if (bus.sram_stall) check("stall_no_cs", 64'(bus.sram_cs), 0);
      if (bus.sram_cs != '0) begin
        if (acc_q.size() == 0) check("cs_unexpected", 64'(bus.sram_cs), 0);
        else begin
          a = acc_q.pop_front();
          check("bank_cs", 64'(bus.sram_cs), 64'(a.cs));
          check("bank_row", 64'(bus.sram_addr), 64'(a.row));
          check("sram_we", 64'(bus.sram_we), 64'(a.we));
          check("ack", 64'(bus.cl_ack), a.we ? 64'(N'(1) << a.owner) : 64'd0);
          if (a.we) begin
            check("wr_nbytes", 64'(bus.cl_nbytes), 64'(a.nb));
            check("wr_last", 64'(bus.cl_last), 64'(a.last));
          end
        end
      end else if (bus.cl_ack != '0) check("ack_without_cs", 64'(bus.cl_ack), 0);
      if (bus.cl_rvalid != '0) begin
        if (ret_q.size() == 0) check("rvalid_unexpected", 64'(bus.cl_rvalid), 0);
        else begin
          r = ret_q.pop_front();
          check("rvalid_owner", 64'(bus.cl_rvalid), 64'(N'(1) << r.owner));
          check("rd_nbytes", 64'(bus.cl_nbytes), 64'(r.nb));
          check("rd_last", 64'(bus.cl_last), 64'(r.last));
          if (r.last) check("done_with_last_rvalid", 64'(bus.cl_done), 64'(bus.cl_rvalid));
        end
      end
      if (bus.cl_done != '0) begin
        last_done_cyc = cyc;
        if (done_q.size() == 0) check("done_unexpected", 64'(bus.cl_done), 0);
        else begin
          e = done_q.pop_front();
          check("done_owner", 64'(bus.cl_done), 64'(N'(1) << e));
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int d0, d1, nb_b, sz;
    logic [AW-1:0] ad;
    burst_t rb;
    rst = 1'b1;
    bus.cl_req = '0; bus.cl_write = '0; bus.cl_addr = '0; bus.cl_size = '0;
    bus.prio_en = 1'b0; bus.prio_client = '0; bus.sram_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 0);
    check("reset_gnt", 64'(bus.cl_gnt), 0);
    check("reset_cs", 64'(bus.sram_cs), 0);
    check("reset_done", 64'(bus.cl_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    add_burst(2, 1'b0, 19'h00040, 96);
    run_scn("read3", 1'b0, 0, 0, 0, 0, d0);
    check("read3_done_latency", 64'(d0), 4);

    add_burst(0, 1'b1, 19'h001E0, 70);
    run_scn("write_tail", 1'b0, 0, 0, 0, 0, d0);
    check("write_done_latency", 64'(d0), 4);

    add_burst(7, 1'b0, 19'h7FFE0, 64);
    run_scn("line_wrap", 1'b0, 0, 0, 0, 0, d0);

    add_burst(6, 1'b1, 19'h00123, 0);
    run_scn("size_zero", 1'b0, 0, 0, 0, 0, d0);
    check("size_zero_done_latency", 64'(d0), 1);

    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) add_burst(c, 1'($urandom), 19'($urandom), $urandom_range(1, 100));
    run_scn("rr_012", 1'b0, 0, 0, 0, 0, d0);

    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) add_burst(c, 1'($urandom), 19'($urandom), $urandom_range(1, 100));
    run_scn("prio_2", 1'b1, 2, 0, 0, 0, d0);

    add_burst(3, 1'b0, 19'h01000, 128);
    run_scn("nostall4", 1'b0, 0, 0, 0, 0, d0);
    add_burst(3, 1'b0, 19'h01000, 128);
    run_scn("stall4", 1'b0, 0, 2, 2, 5, d1);
    check("nostall_done_latency", 64'(d0), 5);
    check("stall_adds_3", 64'(d1 - d0), 3);

    rb.we = 1'b0; rb.addr = 19'h00100; rb.size = 16'd128;
    push_events(4, rb, 2, 1'b0);
    bus.prio_en = 1'b0;
    @(posedge clk); #1;
    bus.cl_write[4] = rb.we; bus.cl_addr[4] = rb.addr; bus.cl_size[4] = rb.size; bus.cl_req[4] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cl_req = '0;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_gnt", 64'(bus.cl_gnt), 0);
    check("rst_cs", 64'(bus.sram_cs), 0);
    check("rst_rvalid", 64'(bus.cl_rvalid), 0);
    check("rst_done", 64'(bus.cl_done), 0);
    repeat (2) @(posedge clk);
    #1;
    check_drained("reset_mid");
    model_ptr = 0;

    add_burst(5, 1'b1, 19'h02000, 40);
    add_burst(7, 1'b0, 19'h03000, 33);
    add_burst(1, 1'b0, 19'h04000, 64);
    run_scn("after_reset", 1'b0, 0, 0, 0, 0, d0);

    for (int s = 0; s < 40; s++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom % 2 == 0) continue;
        nb_b = $urandom_range(1, 3);
        for (int k = 0; k < nb_b; k++) begin
          ad = ($urandom % 4 == 0) ? 19'h7FF00 + 19'($urandom % 256) : 19'($urandom);
          sz = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 200);
          add_burst(c, 1'($urandom), ad, sz);
        end
      end
      run_scn("random", 1'($urandom), $urandom_range(0, N - 1), 1, 0, 0, d0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_bank_scheduler.md
# mem_bank_scheduler

Burst scheduler that shares the 16-bank SRAM farm between line-oriented clients such as FCC, CNN, pool and SW read/write ports. It arbitrates pending burst requests using round-robin with an optional priority override. It breaks each granted burst into one 256-bit line access per cycle, interleaved across banks, and returns per-line valid/ack, last-line byte count and a done pulse to the owner.

## Interface
- NUM_CLIENTS, 8, number of requester ports (CW = $clog2(NUM_CLIENTS))
- ADDR_WIDTH, 19, byte address width into the farm
- SIZE_WIDTH, 16, burst size field width in bytes
- NUM_BANKS, 16, SRAM banks; line index bits [3:0] select the bank
- AGE_LIMIT, 64, wait cycles before a client is aged (only with aging compiled in)
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cl_req  in  NUM_CLIENTS  burst request; held until cl_done
- cl_write  in  NUM_CLIENTS  1 = write burst, 0 = read burst
- cl_addr  in  NUM_CLIENTS x ADDR_WIDTH  start byte address; bits [4:0] ignored
- cl_size  in  NUM_CLIENTS x SIZE_WIDTH  burst length in bytes
- prio_en  in  1  enable priority override
- prio_client  in  CW  index of the priority client
- sram_stall  in  1  farm occupied (DDR demux load); no issue this cycle
- cl_gnt  out  NUM_CLIENTS  one-hot owner; held for the whole burst
- cl_ack  out  NUM_CLIENTS  write line accepted (issue cycle)
- cl_rvalid  out  NUM_CLIENTS  read line data valid on farm output
- cl_last  out  1  qualifies ack/rvalid of the final line
- cl_nbytes  out  6  valid bytes in the current line, 1..32
- cl_done  out  NUM_CLIENTS  one-cycle burst completion pulse
- sram_cs  out  NUM_BANKS  one-hot bank select
- sram_we  out  1  write enable for the selected bank
- sram_addr  out  ADDR_WIDTH-9  row within the bank
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, DONE. All outputs are 0 in reset and IDLE.
- IDLE, any cl_req set: pick the winner, register cl_gnt, and load these values, then go to ISSUE.
  - line = cl_addr[ADDR_WIDTH-1:5]
  - remaining = ceil(size/32)
  - tail = size[4:0]==0 ? 32 : size[4:0]
- Winner selection: if prio_en and cl_req[prio_client], that client wins. Otherwise the first requester at or after rr_ptr, wrapping, wins.
- rr_ptr becomes winner+1 (mod NUM_CLIENTS) at grant.
- cl_size==0: IDLE goes straight to DONE with no SRAM access and no ack/rvalid; cl_done still pulses.
- ISSUE, sram_stall=0, one line per cycle:
  - sram_cs = onehot(line[3:0]), sram_addr = line[ADDR_WIDTH-6:4], sram_we = write.
  - line increments and wraps modulo 2^(ADDR_WIDTH-5).
  - remaining decrements.
- ISSUE, sram_stall=1: no cs, counters hold, the grant holds.
- Write: cl_ack[owner] pulses in the issue cycle. cl_nbytes = 32, except tail on the last line with cl_last=1.
- Read: cl_rvalid[owner], cl_last and cl_nbytes are registered copies of the issue cycle, appearing one cycle later.
- Last line issued: go to DONE. In DONE, cl_done[owner] pulses, cl_gnt drops at the end of the cycle, and the state returns to IDLE.
- A client dropping cl_req mid-burst does not abort the burst. A client re-asserting in the cycle after done is eligible.
- Reset mid-burst: all state, cs, rvalid and rr_ptr (to 0) clear on the next edge. A rvalid already in flight is suppressed.

## Timing
- Request visible at edge N: cl_gnt high after N+1, first sram_cs in cycle N+1.
- L-line burst, no stalls: ISSUE takes L cycles, then DONE 1 cycle. The next grant is decided in the following IDLE cycle, so there are 2 dead cycles between bursts.
- Read data latency: 1 cycle from sram_cs to cl_rvalid. The last rvalid coincides with cl_done.
- Each stall cycle adds exactly one cycle. A read line issued before the stall still returns its rvalid during the stall.

## Configuration
- MEM_SCHED_AGING_EN defined:
  - Each client has a saturating wait counter that increments every cycle it requests without cl_gnt and clears on grant.
  - A client whose counter reached AGE_LIMIT beats both the priority client and round-robin; among aged clients the lowest index wins.
- MEM_SCHED_AGING_EN undefined: no counters; selection is priority then round-robin only.

## Structure
- Package mem_sched_pkg holds:
  - the state enum (IDLE/ISSUE/DONE);
  - LINE_BYTES=32 and LINE_SHIFT=5;
  - function num_lines(size);
  - function tail_bytes(size).
- Sub-module mem_sched_rr_pick: combinational pick of the first set bit of req rotated from ptr. It outputs a one-hot grant and a found flag, and is reused for the aged-set pick.

## Test plan
- Client 2 reads addr 0x00040, size 96: banks 2,3,4 row 0 in consecutive cycles. Then 3 rvalid, the last with cl_last=1, nbytes=32, and cl_done on the third rvalid.
- Client 0 writes addr 0x001E0, size 70: lines 15,16,17 map to bank 15 row 0, then bank 0 row 1, then bank 1 row 1. Three acks; the last has nbytes=6.
- Clients 0,1,2 requesting continuously, prio_en=0: grant order 0,1,2,0,1. With prio_en=1, prio_client=2, every grant goes to 2.
- sram_stall high for 3 cycles during the second line of a 4-line read: no cs during the stall, and cl_done arrives exactly 3 cycles later than the unstalled case.
- rst asserted in the second ISSUE cycle: the next cycle shows all outputs 0 and busy=0, no stray rvalid, and a new request from client 5 is granted as if after reset.
- With MEM_SCHED_AGING_EN, AGE_LIMIT=4, prio_en on client 1, and client 3 requesting: client 3 is granted once its wait counter reaches 4 after its first denied cycle, and the grant goes to 1 again afterwards.
